// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: one carry-propagate slice walks the
// operand pair LSB first, one bit per clock, and reports result/carry/overflow.
module serial_addsub_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] lhs,
    input  logic [DATA_WIDTH-1:0] rhs,
    input  logic                  inv,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] res,
    output logic                  cout,
    output logic                  of
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] a_sh;
    logic [DATA_WIDTH-1:0] b_sh;
    logic [DATA_WIDTH-1:0] r_sh;
    logic [DATA_WIDTH-1:0] r_next;
    logic                  carry;
    logic                  carry_next;
    logic                  sum_bit;
    logic [IDX_W-1:0]      idx;

    always_comb begin
        sum_bit    = a_sh[0] ^ b_sh[0] ^ carry;
        carry_next = (a_sh[0] & b_sh[0]) | ((a_sh[0] | b_sh[0]) & carry);
        r_next     = r_sh >> 1;
        r_next[DATA_WIDTH-1] = sum_bit;
    end

    // On the last bit the pre-update carry is the carry into the MSB, so the
    // overflow flag can be formed directly at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            res   <= '0;
            cout  <= 1'b0;
            of    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_sh  <= lhs;
                        b_sh  <= rhs ^ {DATA_WIDTH{inv}};
                        carry <= inv;
                        idx   <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= r_next;
                    carry <= carry_next;
                    if (idx == LAST_IDX) begin
                        res   <= r_next;
                        cout  <= carry_next;
                        of    <= carry ^ carry_next;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready = (state == S_IDLE) || (state == S_DONE);
    assign busy  = (state == S_RUN);
    assign done  = (state == S_DONE);

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl, exercising an 8-bit and a 1-bit
// instance with the same directed sequence.
module tb_serial_addsub_ctrl;

    typedef struct packed {
        logic [7:0] res;
        logic       cout;
        logic       of;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] lhs;
    logic [7:0] rhs;
    logic       inv;
    int         w_sel;

    logic       start8, ready8, busy8, done8, cout8, of8;
    logic [7:0] res8;
    logic       start1, ready1, busy1, done1, cout1, of1;
    logic [0:0] res1;

    logic       obs_ready, obs_busy, obs_done, obs_cout, obs_of;
    logic [7:0] obs_res;

    exp_t       sb[$];
    logic [7:0] hold_res;
    int         assert_count;
    int         fail_count;

    assign start8 = start && (w_sel == 8);
    assign start1 = start && (w_sel == 1);

    serial_addsub_ctrl #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .lhs(lhs), .rhs(rhs), .inv(inv),
        .ready(ready8), .busy(busy8), .done(done8), .res(res8), .cout(cout8), .of(of8)
    );

    serial_addsub_ctrl #(.DATA_WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .lhs(lhs[0:0]), .rhs(rhs[0:0]), .inv(inv),
        .ready(ready1), .busy(busy1), .done(done1), .res(res1), .cout(cout1), .of(of1)
    );

    always_comb begin
        obs_ready = ready8;
        obs_busy  = busy8;
        obs_done  = done8;
        obs_res   = res8;
        obs_cout  = cout8;
        obs_of    = of8;
        if (w_sel == 1) begin
            obs_ready = ready1;
            obs_busy  = busy1;
            obs_done  = done1;
            obs_res   = {7'b0, res1};
            obs_cout  = cout1;
            obs_of    = of1;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference uses full-width arithmetic and sign-based overflow.
    function automatic exp_t model(input int w, input logic [7:0] l, input logic [7:0] r,
                                   input logic i);
        exp_t       e;
        logic [7:0] mask;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] sum;
        mask   = 8'((9'h1 << w) - 9'h1);
        a      = l & mask;
        b      = (r ^ {8{i}}) & mask;
        sum    = {1'b0, a} + {1'b0, b} + {8'b0, i};
        e.res  = sum[7:0] & mask;
        e.cout = sum[w];
        e.of   = (a[w-1] == b[w-1]) && (e.res[w-1] != a[w-1]);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assert_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s (w=%0d): observed %0h, expected %0h", tag, w_sel,
                   observed, expected);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        hold_res = '0;
    endtask

    task automatic applyStimulus(input logic [7:0] l, input logic [7:0] r, input logic i);
        lhs   = l;
        rhs   = r;
        inv   = i;
        start = 1'b1;
        sb.push_back(model(w_sel, l, r, i));
        @(negedge clk);
        start = 1'b0;
        checkOutput("accept busy", 64'(obs_busy), 64'd1);
    endtask

    task automatic wait_done(input string tag, input int n0);
        exp_t e;
        int   n;
        n = n0;
        while (!obs_done && n < 40) begin
            checkOutput({tag, " res hold"}, 64'(obs_res), 64'(hold_res));
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " latency"}, 64'(n), 64'(w_sel + 1));
        checkOutput({tag, " done"}, 64'(obs_done), 64'd1);
        if (sb.size() == 0) begin
            checkOutput({tag, " scoreboard empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, " res"}, 64'(obs_res), 64'(e.res));
            checkOutput({tag, " cout"}, 64'(obs_cout), 64'(e.cout));
            checkOutput({tag, " of"}, 64'(obs_of), 64'(e.of));
            hold_res = e.res;
        end
    endtask

    task automatic run_suite();
        logic [7:0] vl[4];
        logic [7:0] vr[4];
        logic       vi[4];
        int         adv;
        vl = '{8'h7F, 8'h00, 8'hFF, 8'h80};
        vr = '{8'h01, 8'h01, 8'h01, 8'h01};
        vi = '{1'b0, 1'b1, 1'b0, 1'b1};

        do_reset();
        checkOutput("reset ready", 64'(obs_ready), 64'd1);
        checkOutput("reset busy", 64'(obs_busy), 64'd0);
        checkOutput("reset done", 64'(obs_done), 64'd0);
        checkOutput("reset res", 64'(obs_res), 64'd0);
        checkOutput("reset cout", 64'(obs_cout), 64'd0);
        checkOutput("reset of", 64'(obs_of), 64'd0);

        for (int k = 0; k < 4; k++) begin
            applyStimulus(vl[k], vr[k], vi[k]);
            wait_done("vector", 1);
            @(negedge clk);
            checkOutput("done single pulse", 64'(obs_done), 64'd0);
            checkOutput("idle ready", 64'(obs_ready), 64'd1);
        end

        // A start pulse while running must neither capture nor queue.
        applyStimulus(8'h12, 8'h34, 1'b0);
        if (w_sel > 2) @(negedge clk);
        lhs   = 8'h55;
        rhs   = 8'h66;
        inv   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("midrun ignore", (w_sel > 2) ? 3 : 2);
        @(negedge clk);
        checkOutput("midrun no queue ready", 64'(obs_ready), 64'd1);
        checkOutput("midrun no queue busy", 64'(obs_busy), 64'd0);

        applyStimulus(8'h05, 8'h06, 1'b0);
        wait_done("b2b first", 1);
        lhs   = 8'h03;
        rhs   = 8'h04;
        inv   = 1'b0;
        start = 1'b1;
        sb.push_back(model(w_sel, 8'h03, 8'h04, 1'b0));
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b busy", 64'(obs_busy), 64'd1);
        wait_done("b2b second", 1);
        @(negedge clk);

        applyStimulus(8'h12, 8'h34, 1'b0);
        adv = (w_sel > 4) ? 4 : w_sel - 1;
        repeat (adv) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        hold_res = '0;
        checkOutput("abort ready", 64'(obs_ready), 64'd1);
        checkOutput("abort busy", 64'(obs_busy), 64'd0);
        checkOutput("abort done", 64'(obs_done), 64'd0);
        checkOutput("abort res", 64'(obs_res), 64'd0);
        checkOutput("abort cout", 64'(obs_cout), 64'd0);
        checkOutput("abort of", 64'(obs_of), 64'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("abort no done", 64'(obs_done), 64'd0);
        end

        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("start with rst ignored", 64'(obs_busy), 64'd0);
        @(negedge clk);
        checkOutput("start with rst idle", 64'(obs_ready), 64'd1);

        applyStimulus(8'h12, 8'h34, 1'b0);
        wait_done("fresh", 1);
        @(negedge clk);
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        rst          = 1'b1;
        start        = 1'b0;
        lhs          = '0;
        rhs          = '0;
        inv          = 1'b0;
        hold_res     = '0;
        w_sel        = 8;
        @(negedge clk);
        run_suite();
        w_sel = 1;
        run_suite();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
